// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 8 input vectors of a 3-input circuit, samples its
// output after a programmable settle time and scores the captured table against EXPECTED.
module truth_table_sweeper #(
    parameter logic [7:0]  EXPECTED = 8'hE8,
    parameter int unsigned SETTLE   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] mismatch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0] MC_MAX      = 4'd8;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] idx_r;
    logic [7:0] settle_cnt_r;
    logic [2:0] vec_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [7:0] captured_r;
    logic [3:0] mismatch_count_r;
    logic       sample_s;
    logic [7:0] captured_next_s;

    // Disagreement between a sampled output bit and the expected table entry.
    function automatic logic sample_miss(input logic [7:0] table_v, input logic [2:0] i,
                                         input logic sample_v);
        return sample_v ^ table_v[i];
    endfunction

    // Saturating increment so the count can never wrap past eight.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v >= MC_MAX) begin
            r = MC_MAX;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Next-state decode plus the sample strobe and the table with the pending sample merged.
    always_comb begin
        state_s         = state_r;
        sample_s        = 1'b0;
        captured_next_s = captured_r;
        if ((state_r == ST_RUN) && !abort && (settle_cnt_r == SETTLE_LAST)) begin
            sample_s               = 1'b1;
            captured_next_s[idx_r] = dut_out;
        end else begin
            sample_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // abort outranks the final sample, so it is tested first
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (sample_s && (idx_r == 3'd7)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Vector sequencing, sampling and scoring registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r            <= 3'd0;
            settle_cnt_r     <= 8'd0;
            vec_r            <= 3'd0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            captured_r       <= 8'h00;
            mismatch_count_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        captured_r       <= 8'h00;
                        mismatch_count_r <= 4'd0;
                        pass_r           <= 1'b0;
                        idx_r            <= 3'd0;
                        settle_cnt_r     <= 8'd0;
                        vec_r            <= 3'd0;
                        busy_r           <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                        vec_r  <= 3'd0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy_r       <= 1'b0;
                        vec_r        <= 3'd0;
                        idx_r        <= 3'd0;
                        settle_cnt_r <= 8'd0;
                    end else if (sample_s) begin
                        captured_r       <= captured_next_s;
                        mismatch_count_r <= sample_miss(EXPECTED, idx_r, dut_out) ?
                                            sat_inc(mismatch_count_r) : mismatch_count_r;
                        settle_cnt_r     <= 8'd0;
                        if (idx_r == 3'd7) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            vec_r  <= 3'd0;
                            idx_r  <= 3'd0;
                            pass_r <= (captured_next_s == EXPECTED);
                        end else begin
                            idx_r <= idx_r + 3'd1;
                            vec_r <= idx_r + 3'd1;
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    vec_r  <= 3'd0;
                end
                default: begin
                    busy_r <= 1'b0;
                    vec_r  <= 3'd0;
                end
            endcase
        end
    end

    assign in1            = vec_r[2];
    assign in2            = vec_r[1];
    assign in3            = vec_r[0];
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign captured       = captured_r;
    assign mismatch_count = mismatch_count_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: stimulus pushes expected sweep results,
// negedge monitors pop and compare whenever a sweeper reports done.
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP    = 8'hE8;
    localparam int         S_MAIN = 4;

    typedef struct {
        logic [7:0] cap;
        logic [3:0] mc;
        logic       pas;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, start_aux, abort_aux;
    logic m_out, m_in1, m_in2, m_in3, m_busy, m_done, m_pass;
    logic [7:0] m_cap;
    logic [3:0] m_mc;
    logic a1_out, a1_in1, a1_in2, a1_in3, a1_busy, a1_done, a1_pass;
    logic [7:0] a1_cap;
    logic [3:0] a1_mc;
    logic a3_out, a3_in1, a3_in2, a3_in3, a3_busy, a3_done, a3_pass;
    logic [7:0] a3_cap;
    logic [3:0] a3_mc;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int e0 = -1000;
    int end_cyc = -1000;
    logic mon_en = 1'b0;
    logic [7:0] tt = EXP;
    int dly = 0;
    logic [7:0] t;
    exp_t q_m[$];
    exp_t q_a1[$];
    exp_t q_a3[$];

    truth_table_sweeper #(.EXPECTED(EXP), .SETTLE(S_MAIN)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(m_out),
        .in1(m_in1), .in2(m_in2), .in3(m_in3), .busy(m_busy), .done(m_done),
        .pass(m_pass), .captured(m_cap), .mismatch_count(m_mc));

    truth_table_sweeper #(.EXPECTED(EXP), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .abort(abort_aux), .dut_out(a1_out),
        .in1(a1_in1), .in2(a1_in2), .in3(a1_in3), .busy(a1_busy), .done(a1_done),
        .pass(a1_pass), .captured(a1_cap), .mismatch_count(a1_mc));

    truth_table_sweeper #(.EXPECTED(EXP), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .abort(abort_aux), .dut_out(a3_out),
        .in1(a3_in1), .in2(a3_in2), .in3(a3_in3), .busy(a3_busy), .done(a3_done),
        .pass(a3_pass), .captured(a3_cap), .mismatch_count(a3_mc));

    always @(posedge clk) cyc <= cyc + 1;

    // Circuits under evaluation: main uses table tt, optionally behind a 2-cycle delay;
    // the auxiliary sweepers see majority behind a 2-cycle delay.
    logic m_c0, m_c1, a1_c0, a1_c1, a3_c0, a3_c1;
    logic [7:0] maj_tt = 8'hE8;
    always @(posedge clk) begin
        m_c0  <= tt[{m_in1, m_in2, m_in3}];
        m_c1  <= m_c0;
        a1_c0 <= maj_tt[{a1_in1, a1_in2, a1_in3}];
        a1_c1 <= a1_c0;
        a3_c0 <= maj_tt[{a3_in1, a3_in2, a3_in3}];
        a3_c1 <= a3_c0;
    end
    assign m_out  = (dly == 2) ? m_c1 : tt[{m_in1, m_in2, m_in3}];
    assign a1_out = a1_c1;
    assign a3_out = a3_c1;

    // Reference: the sample for vector i is taken at edge (i+1)*s after start and sees the
    // circuit's response to whatever vector was applied d cycles earlier (zero before start).
    function automatic logic [7:0] model_cap(input logic [7:0] tab, input int s, input int d);
        logic [7:0] r;
        int k, v;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k = (i + 1) * s - d;
            if (k <= 0) v = 0;
            else v = (k - 1) / s;
            if (v > 7) v = 7;
            r[i] = tab[v];
        end
        return r;
    endfunction

    function automatic int popc(input logic [7:0] x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] c, input int dc);
        exp_t e;
        e.cap      = c;
        e.mc       = 4'(popc(c ^ EXP));
        e.pas      = (c == EXP);
        e.done_cyc = dc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Waits pre idle cycles, then issues a start (optionally with abort) to the main sweeper.
    task automatic run_main(input logic [7:0] tab, input int d, input bit push, input int pre,
                            input logic with_abort);
        tt  = tab;
        dly = d;
        repeat (pre) @(negedge clk);
        start   = 1'b1;
        abort   = with_abort;
        e0      = cyc + 1;
        end_cyc = e0 + 8 * S_MAIN;
        if (push) q_m.push_back(mk_exp(model_cap(tab, S_MAIN, d), end_cyc));
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Main monitor: input vector and busy every cycle, scoreboard pop on done.
    always @(negedge clk) begin : mon_main
        logic win;
        logic [2:0] ev;
        exp_t e;
        if (mon_en) begin
            win = (cyc >= e0) && (cyc < end_cyc);
            ev  = win ? 3'((cyc - e0) / S_MAIN) : 3'd0;
            chk("inputs", 32'({m_in1, m_in2, m_in3}), 32'(ev));
            chk("busy", 32'(m_busy), 32'(win));
            if (m_done) begin
                chk("done_expected", 32'(q_m.size() > 0), 32'd1);
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("captured", 32'(m_cap), 32'(e.cap));
                    chk("mismatch_count", 32'(m_mc), 32'(e.mc));
                    chk("pass", 32'(m_pass), 32'(e.pas));
                end
            end
        end
    end

    // Auxiliary monitors for the SETTLE=1 and SETTLE=3 sweepers.
    always @(negedge clk) begin : mon_aux
        exp_t e;
        if (mon_en) begin
            if (a1_done) begin
                chk("s1_done_expected", 32'(q_a1.size() > 0), 32'd1);
                if (q_a1.size() > 0) begin
                    e = q_a1.pop_front();
                    chk("s1_done_cycle", cyc, e.done_cyc);
                    chk("s1_captured", 32'(a1_cap), 32'(e.cap));
                    chk("s1_mismatch_count", 32'(a1_mc), 32'(e.mc));
                    chk("s1_pass", 32'(a1_pass), 32'(e.pas));
                end
            end
            if (a3_done) begin
                chk("s3_done_expected", 32'(q_a3.size() > 0), 32'd1);
                if (q_a3.size() > 0) begin
                    e = q_a3.pop_front();
                    chk("s3_done_cycle", cyc, e.done_cyc);
                    chk("s3_captured", 32'(a3_cap), 32'(e.cap));
                    chk("s3_mismatch_count", 32'(a3_mc), 32'(e.mc));
                    chk("s3_pass", 32'(a3_pass), 32'(e.pas));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_aux = 1'b0; abort_aux = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_captured", 32'(m_cap), 32'h0);
        chk("rst_mismatch", 32'(m_mc), 32'h0);
        chk("rst_pass", 32'(m_pass), 32'h0);
        chk("rst_busy", 32'(m_busy), 32'h0);
        chk("rst_done", 32'(m_done), 32'h0);
        chk("rst_inputs", 32'({m_in1, m_in2, m_in3}), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Majority, stuck-at-0, inverted majority, random circuits, delayed majority.
        run_main(EXP, 0, 1'b1, 3, 1'b0);   wait_until(end_cyc + 1);
        run_main(8'h00, 0, 1'b1, 3, 1'b0); wait_until(end_cyc + 1);
        run_main(8'h17, 0, 1'b1, 3, 1'b0); wait_until(end_cyc + 1);
        for (int n = 0; n < 3; n++) begin
            t = 8'($urandom);
            run_main(t, 0, 1'b1, 3, 1'b0);
            wait_until(end_cyc + 1);
        end
        run_main(EXP, 2, 1'b1, 4, 1'b0);   wait_until(end_cyc + 1);

        // start together with abort in IDLE still launches a sweep.
        t = 8'($urandom);
        run_main(t, 0, 1'b1, 3, 1'b1);     wait_until(end_cyc + 1);

        // Random start pulses during a sweep; start/abort in DONE; restart right after done.
        run_main(EXP, 0, 1'b1, 3, 1'b0);
        while (cyc < end_cyc) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        t = 8'($urandom) | 8'h01;
        run_main(t, 0, 1'b1, 0, 1'b0);
        chk("restart_clear", 32'(m_cap), 32'h0);
        chk("restart_pass", 32'(m_pass), 32'h0);
        wait_until(end_cyc + 1);

        // Abort while vector 3 is applied.
        t = 8'($urandom);
        run_main(t, 0, 1'b0, 3, 1'b0);
        wait_until(e0 + 3 * S_MAIN + 1);
        abort = 1'b1;
        end_cyc = cyc + 1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_captured", 32'(m_cap), 32'({5'b0, t[2:0]}));
        chk("abort_mismatch", 32'(m_mc), 32'(popc((t ^ EXP) & 8'h07)));
        chk("abort_pass", 32'(m_pass), 32'h0);
        repeat (40) @(negedge clk);

        // Reset for one edge while vector 5 is applied, then a clean sweep.
        run_main(EXP, 0, 1'b0, 3, 1'b0);
        wait_until(e0 + 5 * S_MAIN + 1);
        rst_n = 1'b0;
        end_cyc = cyc + 1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_captured", 32'(m_cap), 32'h0);
        chk("midrst_mismatch", 32'(m_mc), 32'h0);
        chk("midrst_pass", 32'(m_pass), 32'h0);
        chk("midrst_done", 32'(m_done), 32'h0);
        repeat (40) @(negedge clk);
        run_main(EXP, 0, 1'b1, 0, 1'b0);   wait_until(end_cyc + 1);

        // Delayed majority against SETTLE=1 (too short) and SETTLE=3 (just enough).
        start_aux = 1'b1;
        q_a1.push_back(mk_exp(model_cap(EXP, 1, 2), cyc + 1 + 8));
        q_a3.push_back(mk_exp(model_cap(EXP, 3, 2), cyc + 1 + 24));
        @(negedge clk);
        start_aux = 1'b0;
        repeat (30) @(negedge clk);

        chk("main_queue_drained", 32'(q_m.size()), 32'h0);
        chk("s1_queue_drained", 32'(q_a1.size()), 32'h0);
        chk("s3_queue_drained", 32'(q_a3.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
